uart_cmd_link: RTL and testbench

- Parametrised serial command link: one UART transmitter, one UART receiver, and a command assembler.
- The receiver packs NUM_BYTES serial bytes (MSB byte first) into one command word and flags it ready for the command processor.
- Adds an inter-byte timeout, framing-error detection, resynchronisation and a configurable baud divisor.
- Sits between the board UART pins and the command dispatch logic.

---
 rtl/uart_cmd_link.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_uart_cmd_link.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_link.sv
// uart_cmd_link: serial command link made of a UART transmitter, a UART
// receiver and a command assembler that packs NUM_BYTES received bytes
// (first byte in the MSBs) into one command word.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   RX           serial input (asynchronous, idles high)
//   TX           serial output (idles high)
//   trmt         one-cycle strobe: transmit tx_data (ignored while busy)
//   tx_data      byte to transmit
//   tx_done      high from the end of a stop bit until the next accepted trmt
//   clr_cmd_rdy  consumer acknowledge for cmd_rdy
//   cmd          assembled command word
//   cmd_rdy      cmd holds a fresh, complete command
//   frm_err      one-cycle pulse: received byte had a low stop bit
//   timeout      one-cycle pulse: partial command dropped after idle gap
//
// Handshake: cmd_rdy rises the cycle after the final stop-bit sample and
// stays high until the cycle after clr_cmd_rdy or until the first byte of
// the next command is accepted; a completion in the same cycle as
// clr_cmd_rdy leaves cmd_rdy high. trmt is accepted only while the
// transmitter is idle.
module uart_cmd_link #(
  parameter int BAUD_DIV    = 2604,
  parameter int NUM_BYTES   = 3,
  parameter int TIMEOUT_CYC = 20 * BAUD_DIV
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   RX,
  output logic                   TX,
  input  logic                   trmt,
  input  logic [7:0]             tx_data,
  output logic                   tx_done,
  input  logic                   clr_cmd_rdy,
  output logic [8*NUM_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  output logic                   frm_err,
  output logic                   timeout
);

  localparam int CW  = 8 * NUM_BYTES;
  localparam int BCW = $clog2(BAUD_DIV);
  localparam int NCW = $clog2(NUM_BYTES + 1);
  localparam int TCW = $clog2(TIMEOUT_CYC);

  localparam logic [BCW-1:0] BAUD_M1 = BCW'(BAUD_DIV - 1);
  localparam logic [BCW-1:0] HALF_M1 = BCW'(BAUD_DIV / 2 - 1);
  localparam logic [NCW-1:0] LAST_IX = NCW'(NUM_BYTES - 1);
  localparam logic [TCW-1:0] TMO_M1  = TCW'(TIMEOUT_CYC - 1);

  // RX_RESYNC waits for the line to return high after a framing error so
  // that a stuck-low or misaligned line cannot start a bogus frame.
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_RESYNC
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  // RX synchroniser and edge-detect history, preset to the idle level
  logic rx_s1_q, rx_s2_q, rx_prev_q;

  rx_state_t      rx_state_q, rx_state_d;
  logic [BCW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;

  logic [NCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]  cmd_buf_q, cmd_buf_d;
  logic [CW-1:0]  cmd_q, cmd_d;
  logic           cmd_rdy_q, cmd_rdy_d;
  logic           frm_err_q, frm_err_d;
  logic           timeout_q, timeout_d;
  logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;

  tx_state_t      tx_state_q, tx_state_d;
  logic [BCW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [7:0]     tx_shift_q, tx_shift_d;
  logic           tx_q, tx_d;
  logic           tx_done_q, tx_done_d;

  logic rx_fall;
  logic byte_ok;

  assign rx_fall = rx_prev_q & ~rx_s2_q;

  // Receiver and assembler next-state logic
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_cnt_d = byte_cnt_q;
    cmd_buf_d  = cmd_buf_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    frm_err_d  = 1'b0;
    timeout_d  = 1'b0;
    tmo_cnt_d  = tmo_cnt_q;
    byte_ok    = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) rx_state_d = RX_START;
      end
      RX_START: begin
        // Resample mid start bit; a high line here was a glitch.
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BAUD_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BAUD_M1) begin
          rx_cnt_d = '0;
          if (rx_s2_q) begin
            byte_ok    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            frm_err_d  = 1'b1;
            byte_cnt_d = '0;
            rx_state_d = RX_RESYNC;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_RESYNC: begin
        if (rx_s2_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase

    // Clear requests first so that a completion below overrides them.
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;

    // Each byte lands in its slot by position; since slots fill in order
    // 0..NUM_BYTES-1 this matches an MSB-first shift register.
    if (byte_ok) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (byte_cnt_q == NCW'(i)) cmd_buf_d[CW-1-8*i -: 8] = rx_shift_q;
      end
      if (byte_cnt_q == '0) cmd_rdy_d = 1'b0;
      if (byte_cnt_q == LAST_IX) begin
        cmd_d      = cmd_buf_d;
        cmd_rdy_d  = 1'b1;
        byte_cnt_d = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end

    // Inter-byte timeout: only counts idle line time inside a partial
    // command; leaving IDLE (start bit seen) reloads it.
    if (rx_state_q == RX_IDLE && byte_cnt_q != '0) begin
      if (tmo_cnt_q == TMO_M1) begin
        tmo_cnt_d  = '0;
        timeout_d  = 1'b1;
        byte_cnt_d = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // Transmitter next-state logic; TX is registered so the line is glitch-free
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_d       = tx_q;
    tx_done_d  = tx_done_q;

    case (tx_state_q)
      TX_IDLE: begin
        tx_d     = 1'b1;
        tx_cnt_d = '0;
        if (trmt) begin
          tx_shift_d = tx_data;
          tx_done_d  = 1'b0;
          tx_d       = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BAUD_M1) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BAUD_M1) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_d       = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 1'b1;
            tx_d       = tx_shift_q[1];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BAUD_M1) begin
          tx_cnt_d   = '0;
          tx_done_d  = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      byte_cnt_q <= '0;
      cmd_buf_q  <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
      tmo_cnt_q  <= '0;
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      byte_cnt_q <= byte_cnt_d;
      cmd_buf_q  <= cmd_buf_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      frm_err_q  <= frm_err_d;
      timeout_q  <= timeout_d;
      tmo_cnt_q  <= tmo_cnt_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_q       <= tx_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign TX      = tx_q;
  assign tx_done = tx_done_q;
  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign frm_err = frm_err_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_cmd_link.sv
// Bench for uart_cmd_link: a 3-byte instance with TX looped to RX (RX can be
// overridden to inject bad frames and glitches), plus 1-byte and 4-byte
// instances. A byte-level model predicts commands, timeouts and framing
// errors; an expected queue holds predicted command words.
module tb_uart_cmd_link;

  localparam int BD  = 16;
  localparam int TMO = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance, NUM_BYTES = 3
  logic        tx_m, rx_m, trmt_m, tx_done_m, clr_m, cmd_rdy_m, frm_err_m, timeout_m;
  logic [7:0]  txd_m;
  logic [23:0] cmd_m;
  logic        rx_force_en, rx_force;
  assign rx_m = rx_force_en ? rx_force : tx_m;

  // auxiliary instances
  logic        tx_1, trmt_1, tx_done_1, clr_1, cmd_rdy_1, frm_err_1, timeout_1;
  logic [7:0]  txd_1, cmd_1;
  logic        tx_4, trmt_4, tx_done_4, clr_4, cmd_rdy_4, frm_err_4, timeout_4;
  logic [7:0]  txd_4;
  logic [31:0] cmd_4;

  uart_cmd_link #(.BAUD_DIV(BD), .NUM_BYTES(3), .TIMEOUT_CYC(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n), .RX(rx_m), .TX(tx_m), .trmt(trmt_m), .tx_data(txd_m),
    .tx_done(tx_done_m), .clr_cmd_rdy(clr_m), .cmd(cmd_m), .cmd_rdy(cmd_rdy_m),
    .frm_err(frm_err_m), .timeout(timeout_m));

  uart_cmd_link #(.BAUD_DIV(BD), .NUM_BYTES(1), .TIMEOUT_CYC(TMO)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .RX(tx_1), .TX(tx_1), .trmt(trmt_1), .tx_data(txd_1),
    .tx_done(tx_done_1), .clr_cmd_rdy(clr_1), .cmd(cmd_1), .cmd_rdy(cmd_rdy_1),
    .frm_err(frm_err_1), .timeout(timeout_1));

  uart_cmd_link #(.BAUD_DIV(BD), .NUM_BYTES(4), .TIMEOUT_CYC(TMO)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .RX(tx_4), .TX(tx_4), .trmt(trmt_4), .tx_data(txd_4),
    .tx_done(tx_done_4), .clr_cmd_rdy(clr_4), .cmd(cmd_4), .cmd_rdy(cmd_rdy_4),
    .frm_err(frm_err_4), .timeout(timeout_4));

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  mq[$];      // bytes of the partial command (model)
  logic [63:0] exp_q[$];   // predicted command words
  logic [63:0] last_cmd = '0;
  int exp_frm = 0, exp_tmo = 0;
  int n_frm = 0, n_tmo = 0;

  // pulse monitors on the main instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (frm_err_m) n_frm++;
      if (timeout_m) n_tmo++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: a valid byte joins the partial command; NUM_BYTES of them
  // form a command word, first byte most significant
  task automatic model_byte(input logic [7:0] b, input int nb);
    logic [63:0] v;
    mq.push_back(b);
    if (mq.size() == nb) begin
      v = '0;
      foreach (mq[i]) v = (v << 8) | 64'(mq[i]);
      exp_q.push_back(v);
      mq.delete();
    end
  endtask

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    txd_m = b;
    trmt_m = 1'b1;
    @(negedge clk);
    trmt_m = 1'b0;
  endtask

  task automatic finish_tx(input logic [7:0] b);
    int k = 0;
    while (!tx_done_m && k < 400) begin
      @(negedge clk);
      k++;
    end
    check("tx_done_wait", tx_done_m, 1'b1);
    model_byte(b, 3);
    if (exp_q.size() != 0) begin
      last_cmd = exp_q.pop_front();
      check("cmd_rdy_set", cmd_rdy_m, 1'b1);
      check("cmd_value", cmd_m, last_cmd);
    end else begin
      check("cmd_rdy_low", cmd_rdy_m, 1'b0);
      check("cmd_hold", cmd_m, last_cmd);
    end
  endtask

  task automatic send_m(input logic [7:0] b);
    start_tx(b);
    finish_tx(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    // gaps are chosen far from the threshold so the outcome is unambiguous
    if (n > TMO && mq.size() != 0) begin
      mq.delete();
      exp_tmo++;
    end
  endtask

  task automatic drive_raw(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx_force_en = 1'b1;
    rx_force = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_force = b[i];
      repeat (BD) @(negedge clk);
    end
    rx_force = stop;
    repeat (BD) @(negedge clk);
    rx_force = 1'b1;
    repeat (24) @(negedge clk);
    rx_force_en = 1'b0;
    if (!stop) begin
      mq.delete();
      exp_frm++;
    end else begin
      model_byte(b, 3);
    end
  endtask

  task automatic glitch();
    @(negedge clk);
    rx_force_en = 1'b1;
    rx_force = 1'b0;
    repeat (4) @(negedge clk);
    rx_force = 1'b1;
    repeat (30) @(negedge clk);
    rx_force_en = 1'b0;
  endtask

  task automatic check_pulses(input string tag);
    check({tag, "_frm_cnt"}, 64'(n_frm), 64'(exp_frm));
    check({tag, "_tmo_cnt"}, 64'(n_tmo), 64'(exp_tmo));
  endtask

  // auxiliary instances share one partial-byte queue (used one at a time)
  logic [7:0] aq[$];
  task automatic aux_send(input int nb, input logic [7:0] b);
    int k = 0;
    logic done, rdy;
    logic [63:0] c, v;
    @(negedge clk);
    if (nb == 1) begin txd_1 = b; trmt_1 = 1'b1; end
    else         begin txd_4 = b; trmt_4 = 1'b1; end
    @(negedge clk);
    trmt_1 = 1'b0;
    trmt_4 = 1'b0;
    done = 1'b0;
    while (!done && k < 400) begin
      @(negedge clk);
      k++;
      done = (nb == 1) ? tx_done_1 : tx_done_4;
    end
    check("aux_tx_done", done, 1'b1);
    rdy = (nb == 1) ? cmd_rdy_1 : cmd_rdy_4;
    c   = (nb == 1) ? 64'(cmd_1) : 64'(cmd_4);
    aq.push_back(b);
    if (aq.size() == nb) begin
      v = '0;
      foreach (aq[i]) v = (v << 8) | 64'(aq[i]);
      aq.delete();
      check("aux_cmd_rdy", rdy, 1'b1);
      check("aux_cmd", c, v);
    end else begin
      check("aux_cmd_rdy_low", rdy, 1'b0);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    logic [7:0] b;
    trmt_m = 1'b0; txd_m = '0; clr_m = 1'b0;
    rx_force_en = 1'b0; rx_force = 1'b1;
    trmt_1 = 1'b0; txd_1 = '0; clr_1 = 1'b0;
    trmt_4 = 1'b0; txd_4 = '0; clr_4 = 1'b0;

    // reset values
    repeat (5) @(negedge clk);
    check("rst_tx", tx_m, 1'b1);
    check("rst_outs", {tx_done_m, cmd_rdy_m, frm_err_m, timeout_m}, 4'b0);
    check("rst_cmd", cmd_m, 24'h0);
    check("rst_aux", {tx_1, tx_4, tx_done_1, tx_done_4, cmd_rdy_1, cmd_rdy_4}, 6'b110000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // basic command
    send_m(8'h55); send_m(8'hAA); send_m(8'hE3);
    check_pulses("basic");

    // consumer acknowledge
    @(negedge clk); clr_m = 1'b1;
    @(negedge clk); clr_m = 1'b0;
    check("clr_rdy", cmd_rdy_m, 1'b0);
    check("clr_hold", cmd_m, 24'h55AAE3);

    // first byte of a new command drops cmd_rdy (checked in finish_tx)
    send_m(8'h12); send_m(8'h34); send_m(8'h56);
    send_m(8'h12);

    // framing error clears the partial command, then a glitch is ignored
    drive_raw(8'h3C, 1'b0);
    check_pulses("frame");
    glitch();
    send_m(8'h01); send_m(8'h02); send_m(8'h03);
    check_pulses("after_frame");

    // inter-byte timeout
    send_m(8'hA1); send_m(8'hB2);
    idle(TMO + 50);
    check("tmo_rdy", cmd_rdy_m, 1'b0);
    check_pulses("timeout");
    send_m(8'hC3); send_m(8'hD4); send_m(8'hE5);

    // trmt while busy is ignored; frame length is 10 bit times
    start_tx(8'h55);
    t0 = cyc;
    repeat (40) @(negedge clk);
    start_tx(8'h77);
    finish_tx(8'h55);
    check("tx_done_latency", 64'(cyc - t0), 64'(10 * BD));
    send_m(8'h66); send_m(8'h88);

    // reset in the middle of the second byte
    send_m(8'h99);
    start_tx(8'h5A);
    repeat (70) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_tx", tx_m, 1'b1);
    check("midrst_outs", {tx_done_m, cmd_rdy_m, frm_err_m, timeout_m}, 4'b0);
    check("midrst_cmd", cmd_m, 24'h0);
    mq.delete(); exp_q.delete(); last_cmd = '0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_m(8'h11); send_m(8'h22); send_m(8'h33);
    check_pulses("after_reset");

    // randomized bytes, gaps and glitches
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom_range(0, 255));
      send_m(b);
      if ($urandom_range(0, 7) == 0) glitch();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(TMO + 80, TMO + 200));
      else                           idle($urandom_range(0, 60));
    end
    check_pulses("random");

    // NUM_BYTES = 1 and NUM_BYTES = 4
    aq.delete();
    aux_send(1, 8'h55); aux_send(1, 8'hAA); aux_send(1, 8'hE3);
    aq.delete();
    aux_send(4, 8'hDE); aux_send(4, 8'hAD); aux_send(4, 8'hBE); aux_send(4, 8'hEF);
    check("nb4_value", 64'(cmd_4), 64'hDEADBEEF);
    for (int i = 0; i < 8; i++) aux_send(4, 8'($urandom_range(0, 255)));
    check("aux_no_err", {frm_err_1, timeout_1, frm_err_4, timeout_4}, 4'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
